dmem_arbiter: RTL and testbench

Sequencer/arbiter that shares the single byte-wide port of the data memory between three requesters: the scalar load/store unit, the vector load/store unit (4 byte lanes) and the VGA scan-out fetcher. Vector requests are serialized into four consecutive byte accesses. VGA reads are real-time and may interleave between vector beats. Sits between the CPU/VGA logic and a single-port, combinational-read, synchronous-write byte RAM.

---
 rtl/dmem_arbiter.sv | 238 +++++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shares the byte-wide data-memory port between scalar LSU, vector LSU (4 serialized beats)
// and the VGA fetcher; VGA may slip in between vector beats.
module dmem_arbiter #(
    parameter int MEM_DEPTH = 651
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_req,
    input  logic        s_we,
    input  logic [31:0] s_addr,
    input  logic [7:0]  s_wdata,
    output logic        s_ready,
    output logic [7:0]  s_rdata,
    input  logic        v_req,
    input  logic        v_we,
    input  logic [31:0] v_addr  [0:3],
    input  logic [7:0]  v_wdata [0:3],
    output logic        v_ready,
    output logic [7:0]  v_rdata [0:3],
    input  logic        g_req,
    input  logic [31:0] g_addr,
    output logic        g_ready,
    output logic [7:0]  g_rdata,
    output logic        m_we,
    output logic [31:0] m_addr,
    output logic [7:0]  m_wdata,
    input  logic [7:0]  m_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] S_ACC = 2'd1;
    localparam logic [1:0] G_ACC = 2'd2;
    localparam logic [1:0] V_ACC = 2'd3;

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_DEPTH);

    logic [1:0]  state_q, state_d;
    logic [1:0]  vb_q, vb_d;
    logic        last_v_q, last_v_d;
    logic        resume_q, resume_d;
    logic        s_ready_q, s_ready_d;
    logic        v_ready_q, v_ready_d;
    logic        g_ready_q, g_ready_d;
    logic [7:0]  s_rdata_q, s_rdata_d;
    logic [7:0]  g_rdata_q, g_rdata_d;
    logic [7:0]  v_rdata_q [0:3];
    logic [7:0]  v_rdata_d [0:3];
    logic [31:0] m_addr_q, m_addr_d;
    logic [7:0]  m_wdata_q, m_wdata_d;

    logic [31:0] s_addr_q, s_addr_d;
    logic        s_we_q, s_we_d;
    logic [7:0]  s_wdata_q, s_wdata_d;
    logic [31:0] g_addr_q, g_addr_d;
    logic        v_we_q, v_we_d;
    logic [31:0] v_addr_q  [0:3];
    logic [31:0] v_addr_d  [0:3];
    logic [7:0]  v_wdata_q [0:3];
    logic [7:0]  v_wdata_d [0:3];

    logic        s_go, v_go, g_go;
    logic        s_grant, v_grant, g_grant;
    logic [31:0] acc_addr;
    logic [7:0]  acc_wdata;
    logic        acc_we;
    logic        in_range;
    logic [7:0]  rd_byte;

    // A request seen while its own ready pulse is high is the tail of the finished one.
    assign s_go = s_req & ~s_ready_q;
    assign v_go = v_req & ~v_ready_q;
    assign g_go = g_req & ~g_ready_q;

    always_comb begin
        acc_addr  = m_addr_q;
        acc_wdata = m_wdata_q;
        acc_we    = 1'b0;
        unique case (state_q)
            S_ACC: begin
                acc_addr  = s_addr_q;
                acc_wdata = s_wdata_q;
                acc_we    = s_we_q;
            end
            G_ACC: acc_addr = g_addr_q;
            V_ACC: begin
                acc_addr  = v_addr_q[vb_q];
                acc_wdata = v_wdata_q[vb_q];
                acc_we    = v_we_q;
            end
            default: ;
        endcase
    end

    assign in_range = acc_addr < MEM_LIMIT;
    assign rd_byte  = in_range ? m_rdata : 8'h00;
    assign m_addr   = acc_addr;
    assign m_wdata  = acc_wdata;
    assign m_we     = acc_we & in_range;

    always_comb begin
        state_d   = state_q;
        vb_d      = vb_q;
        last_v_d  = last_v_q;
        resume_d  = resume_q;
        s_ready_d = 1'b0;
        v_ready_d = 1'b0;
        g_ready_d = 1'b0;
        s_rdata_d = s_rdata_q;
        g_rdata_d = g_rdata_q;
        v_rdata_d = v_rdata_q;
        m_addr_d  = acc_addr;
        m_wdata_d = acc_wdata;
        s_grant   = 1'b0;
        v_grant   = 1'b0;
        g_grant   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (g_go) begin
                    g_grant  = 1'b1;
                    resume_d = 1'b0;
                    state_d  = G_ACC;
                end else if (s_go && (!v_go || last_v_q)) begin
                    s_grant  = 1'b1;
                    last_v_d = 1'b0;
                    state_d  = S_ACC;
                end else if (v_go) begin
                    v_grant  = 1'b1;
                    last_v_d = 1'b1;
                    vb_d     = 2'd0;
                    state_d  = V_ACC;
                end
            end
            S_ACC: begin
                s_rdata_d = rd_byte;
                s_ready_d = 1'b1;
                state_d   = IDLE;
            end
            G_ACC: begin
                g_rdata_d = rd_byte;
                g_ready_d = 1'b1;
                resume_d  = 1'b0;
                state_d   = resume_q ? V_ACC : IDLE;
            end
            V_ACC: begin
                if (!v_we_q) begin
                    v_rdata_d[vb_q] = rd_byte;
                end
                if (vb_q == 2'd3) begin
                    vb_d      = 2'd0;
                    v_ready_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    vb_d = 2'(vb_q + 2'd1);
                    if (g_go) begin
                        g_grant  = 1'b1;
                        resume_d = 1'b1;
                        state_d  = G_ACC;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        s_addr_d  = s_addr_q;
        s_we_d    = s_we_q;
        s_wdata_d = s_wdata_q;
        g_addr_d  = g_addr_q;
        v_we_d    = v_we_q;
        v_addr_d  = v_addr_q;
        v_wdata_d = v_wdata_q;
        if (s_grant) begin
            s_addr_d  = s_addr;
            s_we_d    = s_we;
            s_wdata_d = s_wdata;
        end
        if (g_grant) begin
            g_addr_d = g_addr;
        end
        if (v_grant) begin
            v_we_d    = v_we;
            v_addr_d  = v_addr;
            v_wdata_d = v_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            vb_q      <= 2'd0;
            last_v_q  <= 1'b1;
            resume_q  <= 1'b0;
            s_ready_q <= 1'b0;
            v_ready_q <= 1'b0;
            g_ready_q <= 1'b0;
            s_rdata_q <= 8'h00;
            g_rdata_q <= 8'h00;
            for (int i = 0; i < 4; i++) begin
                v_rdata_q[i] <= 8'h00;
            end
            m_addr_q  <= 32'h0;
            m_wdata_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            vb_q      <= vb_d;
            last_v_q  <= last_v_d;
            resume_q  <= resume_d;
            s_ready_q <= s_ready_d;
            v_ready_q <= v_ready_d;
            g_ready_q <= g_ready_d;
            s_rdata_q <= s_rdata_d;
            g_rdata_q <= g_rdata_d;
            v_rdata_q <= v_rdata_d;
            m_addr_q  <= m_addr_d;
            m_wdata_q <= m_wdata_d;
        end
    end

    // Request latches carry data only; they are always loaded before they are used.
    always_ff @(posedge clk) begin
        s_addr_q  <= s_addr_d;
        s_we_q    <= s_we_d;
        s_wdata_q <= s_wdata_d;
        g_addr_q  <= g_addr_d;
        v_we_q    <= v_we_d;
        v_addr_q  <= v_addr_d;
        v_wdata_q <= v_wdata_d;
    end

    assign s_ready = s_ready_q;
    assign v_ready = v_ready_q;
    assign g_ready = g_ready_q;
    assign s_rdata = s_rdata_q;
    assign g_rdata = g_rdata_q;
    assign v_rdata = v_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: table of single accesses, hand-built vector/VGA/reset sequences,
// and random traffic checked against a byte-array memory model.
module tb_dmem_arbiter;
    localparam int MEM_DEPTH = 651;
    localparam int BOUND     = 24;

    typedef struct {
        bit          is_g;
        bit          we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        int          exp_nwr;
    } single_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_req, s_we, s_ready;
    logic [31:0] s_addr;
    logic [7:0]  s_wdata, s_rdata;
    logic        v_req, v_we, v_ready;
    logic [31:0] v_addr  [0:3];
    logic [7:0]  v_wdata [0:3];
    logic [7:0]  v_rdata [0:3];
    logic        g_req, g_ready;
    logic [31:0] g_addr;
    logic [7:0]  g_rdata;
    logic        m_we;
    logic [31:0] m_addr;
    logic [7:0]  m_wdata, m_rdata;

    logic [7:0]  ram     [0:1023];
    logic [7:0]  ref_mem [0:1023];
    bit          preloaded = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [31:0] tv_addr [0:3];
    logic [7:0]  tv_wd   [0:3];
    logic [7:0]  vrd     [0:3];
    logic [31:0] wlog    [0:3];
    logic [7:0]  grd;
    int          vlat, glat, nwr;
    single_t     tbl [10];

    dmem_arbiter #(.MEM_DEPTH(MEM_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .v_req(v_req), .v_we(v_we), .v_addr(v_addr), .v_wdata(v_wdata),
        .v_ready(v_ready), .v_rdata(v_rdata),
        .g_req(g_req), .g_addr(g_addr), .g_ready(g_ready), .g_rdata(g_rdata),
        .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    // Single-port RAM: combinational read, write on the rising edge; contents preset to addr^0x5A.
    assign m_rdata = (m_addr < 32'd1024) ? ram[m_addr[9:0]] : 8'hEE;
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < 1024; i++) ram[i] <= 8'(i) ^ 8'h5A;
            preloaded <= 1'b1;
        end else if (m_we && m_addr < 32'd1024) begin
            ram[m_addr[9:0]] <= m_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_read(input logic [31:0] a);
        return (a < MEM_DEPTH) ? ref_mem[a[9:0]] : 8'h00;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [7:0] d);
        if (a < MEM_DEPTH) ref_mem[a[9:0]] = d;
    endtask

    task automatic single_txn(input string tag, input bit is_g, input bit we, input logic [31:0] a,
                              input logic [7:0] d, input logic [7:0] exp_rd, input int exp_nwr);
        int lat;
        int wcnt;
        logic [31:0] waddr;
        logic [7:0]  rd;
        lat = 0; wcnt = 0; waddr = '0; rd = '0;
        if (is_g) begin
            g_req = 1'b1; g_addr = a;
        end else begin
            s_req = 1'b1; s_we = we; s_addr = a; s_wdata = d;
        end
        for (int c = 1; c <= BOUND; c++) begin
            @(negedge clk);
            if (c == 1) begin
                s_addr = ~a; s_wdata = ~d; g_addr = ~a; s_we = ~we;
            end
            if (m_we) begin wcnt++; waddr = m_addr; end
            if (is_g ? g_ready : s_ready) begin
                lat = c; rd = is_g ? g_rdata : s_rdata;
                break;
            end
        end
        s_req = 1'b0; g_req = 1'b0; s_we = 1'b0;
        @(negedge clk);
        check({tag, " latency"}, lat, 2);
        check({tag, " write count"}, wcnt, exp_nwr);
        if (exp_nwr > 0) check({tag, " write addr"}, waddr, a);
        if (is_g || !we) begin
            check({tag, " rdata"}, rd, exp_rd);
            check({tag, " rdata hold"}, is_g ? g_rdata : s_rdata, exp_rd);
        end
        check({tag, " idle m_addr hold"}, {m_we, m_addr}, {1'b0, a});
    endtask

    task automatic run_vec(input bit we, input int gbeat, input logic [31:0] gaddr_in);
        vlat = 0; glat = 0; nwr = 0; grd = '0;
        for (int i = 0; i < 4; i++) begin
            wlog[i] = '0; vrd[i] = '0;
            v_addr[i] = tv_addr[i]; v_wdata[i] = tv_wd[i];
        end
        v_req = 1'b1; v_we = we;
        for (int c = 1; c <= BOUND; c++) begin
            @(negedge clk);
            if (c == 1) begin
                for (int i = 0; i < 4; i++) begin
                    v_addr[i] = ~tv_addr[i]; v_wdata[i] = ~tv_wd[i];
                end
                v_we = ~we;
            end
            if (m_we) begin
                if (nwr < 4) wlog[nwr] = m_addr;
                nwr++;
            end
            if (v_ready && vlat == 0) begin vlat = c; vrd = v_rdata; v_req = 1'b0; end
            if (g_ready && glat == 0) begin glat = c; grd = g_rdata; g_req = 1'b0; end
            if (gbeat < 4 && c == gbeat + 1) begin g_req = 1'b1; g_addr = gaddr_in; end
            if (vlat != 0 && (gbeat >= 4 || glat != 0)) break;
        end
        v_req = 1'b0; g_req = 1'b0; v_we = 1'b0;
        @(negedge clk);
    endtask

    // Expectations come from the memory model: lanes commit in order, and a VGA read raised
    // during beat b observes lanes 0..b (or all four if it waits until the vector is done).
    task automatic vec_txn(input string tag, input bit we, input int gbeat, input logic [31:0] gaddr_in);
        logic [7:0]  exp_g;
        logic [7:0]  exp_v [0:3];
        logic [31:0] exp_w [0:3];
        int          nbefore;
        int          exp_nwr;
        nbefore = (gbeat <= 2) ? gbeat + 1 : 4;
        exp_nwr = 0; exp_g = '0;
        for (int i = 0; i < 4; i++) begin
            exp_v[i] = '0; exp_w[i] = '0;
            if (i == nbefore && gbeat < 4) exp_g = ref_read(gaddr_in);
            if (we) begin
                if (tv_addr[i] < MEM_DEPTH) begin
                    exp_w[exp_nwr] = tv_addr[i];
                    exp_nwr++;
                end
                ref_write(tv_addr[i], tv_wd[i]);
            end else begin
                exp_v[i] = ref_read(tv_addr[i]);
            end
        end
        if (nbefore == 4 && gbeat < 4) exp_g = ref_read(gaddr_in);
        run_vec(we, gbeat, gaddr_in);
        check({tag, " v latency"}, vlat, (gbeat <= 2) ? 6 : 5);
        check({tag, " write count"}, nwr, exp_nwr);
        for (int i = 0; i < exp_nwr; i++) check($sformatf("%s write[%0d] addr", tag, i), wlog[i], exp_w[i]);
        if (!we) begin
            for (int i = 0; i < 4; i++) check($sformatf("%s v_rdata[%0d]", tag, i), vrd[i], exp_v[i]);
        end
        if (gbeat < 4) begin
            check({tag, " g latency"}, glat, (gbeat <= 2) ? gbeat + 3 : 7);
            check({tag, " g_rdata"}, grd, exp_g);
        end
    endtask

    initial begin
        byte pulses[$];
        int  vr_cnt;
        rst_n = 1'b0;
        s_req = 1'b0; s_we = 1'b0; s_addr = 32'd20; s_wdata = '0;
        v_req = 1'b0; v_we = 1'b0;
        g_req = 1'b0; g_addr = '0;
        for (int i = 0; i < 4; i++) begin
            v_addr[i] = 32'd30 + 32'(i); v_wdata[i] = '0;
            tv_addr[i] = '0; tv_wd[i] = '0;
        end
        for (int i = 0; i < 1024; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        tbl[0] = '{1'b0, 1'b1, 32'd10,  8'hA5, 8'h00, 1};
        tbl[1] = '{1'b0, 1'b0, 32'd10,  8'h00, 8'hA5, 0};
        tbl[2] = '{1'b0, 1'b1, 32'd651, 8'hFF, 8'h00, 0};
        tbl[3] = '{1'b0, 1'b0, 32'd651, 8'h00, 8'h00, 0};
        tbl[4] = '{1'b0, 1'b0, 32'd700, 8'h00, 8'h00, 0};
        tbl[5] = '{1'b0, 1'b1, 32'd650, 8'h3C, 8'h00, 1};
        tbl[6] = '{1'b0, 1'b0, 32'd650, 8'h00, 8'h3C, 0};
        tbl[7] = '{1'b1, 1'b0, 32'd200, 8'h00, 8'h92, 0};
        tbl[8] = '{1'b1, 1'b0, 32'd651, 8'h00, 8'h00, 0};
        tbl[9] = '{1'b0, 1'b0, 32'd0,   8'h00, 8'h5A, 0};

        // Reset values, with scalar and vector both requesting
        s_req = 1'b1; v_req = 1'b1;
        repeat (3) @(negedge clk);
        check("reset readies/m_we", {s_ready, v_ready, g_ready, m_we}, 4'b0000);
        check("reset m_addr", m_addr, 32'h0);
        check("reset m_wdata", m_wdata, 8'h00);
        check("reset s/g rdata", {s_rdata, g_rdata}, 16'h0);
        check("reset v_rdata", {v_rdata[0], v_rdata[1], v_rdata[2], v_rdata[3]}, 32'h0);

        rst_n = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (s_ready) pulses.push_back(8'h53);
            if (v_ready) pulses.push_back(8'h56);
        end
        s_req = 1'b0; v_req = 1'b0;
        repeat (8) @(negedge clk);
        check("rr pulse count >= 6", pulses.size() >= 6, 1);
        if (pulses.size() > 0) check("rr first grant scalar", pulses[0], 8'h53);
        for (int i = 1; i < pulses.size(); i++)
            check($sformatf("rr alternation %0d", i), pulses[i] != pulses[i-1], 1);

        for (int i = 0; i < 10; i++) begin
            single_txn($sformatf("tbl[%0d]", i), tbl[i].is_g, tbl[i].we, tbl[i].addr,
                       tbl[i].wdata, tbl[i].exp_rd, tbl[i].exp_nwr);
            if (!tbl[i].is_g && tbl[i].we) ref_write(tbl[i].addr, tbl[i].wdata);
        end

        for (int i = 0; i < 4; i++) begin
            tv_addr[i] = 32'd100 + 32'(i); tv_wd[i] = 8'(i + 1);
        end
        vec_txn("vec write 100..103", 1'b1, 4, '0);
        vec_txn("vec read 100..103", 1'b0, 4, '0);
        check("vec read lane data", {vrd[0], vrd[1], vrd[2], vrd[3]}, 32'h01020304);
        vec_txn("vec read + vga@beat1", 1'b0, 1, 32'd200);
        check("vga ready before v_ready", glat < vlat, 1);
        check("vga 200 data", grd, 8'h92);

        // Reset while the vector is on beat 2
        for (int i = 0; i < 4; i++) begin
            tv_addr[i] = 32'd300 + 32'(i); tv_wd[i] = 8'h11 + 8'(i);
            v_addr[i] = tv_addr[i]; v_wdata[i] = tv_wd[i];
        end
        v_req = 1'b1; v_we = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("beat2 write in progress", {m_we, m_addr}, {1'b1, 32'd302});
        rst_n = 1'b0;
        #1;
        check("async reset m_we drop", m_we, 1'b0);
        check("async reset outputs", {s_ready, v_ready, g_ready, m_addr, m_wdata}, '0);
        v_req = 1'b0; v_we = 1'b0;
        vr_cnt = 0;
        repeat (2) begin @(negedge clk); if (v_ready) vr_cnt++; end
        rst_n = 1'b1;
        repeat (4) begin @(negedge clk); if (v_ready) vr_cnt++; end
        check("no v_ready after abort", vr_cnt, 0);
        check("lanes before reset committed", {ram[300], ram[301]}, 16'h1112);
        check("aborted lane not written", ram[302], 8'h74);
        ref_write(32'd300, 8'h11); ref_write(32'd301, 8'h12);
        single_txn("post-reset scalar read 301", 1'b0, 1'b0, 32'd301, 8'h00, 8'h12, 0);

        for (int n = 0; n < 40; n++) begin
            int          kind;
            logic [31:0] a;
            logic [7:0]  d;
            bit          we;
            kind = $urandom_range(0, 2);
            a    = $urandom_range(0, 760);
            d    = 8'($urandom);
            we   = 1'($urandom);
            if (kind == 1) begin
                int          gb;
                logic [31:0] ga;
                for (int i = 0; i < 4; i++) begin
                    tv_addr[i] = a + $urandom_range(0, 3);
                    tv_wd[i]   = 8'($urandom);
                end
                gb = $urandom_range(0, 5);
                ga = $urandom_range(0, 1) ? tv_addr[$urandom_range(0, 3)] : 32'($urandom_range(0, 760));
                vec_txn($sformatf("rnd%0d vec", n), we, gb, ga);
            end else begin
                bit is_g;
                is_g = (kind == 2);
                single_txn($sformatf("rnd%0d %s", n, is_g ? "vga" : "scalar"), is_g, we, a, d,
                           ref_read(a), (!is_g && we && a < MEM_DEPTH) ? 1 : 0);
                if (!is_g && we) ref_write(a, d);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
